// File: rtl/riscpipe_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, opcode field layout,
// legal opcode range and the fetch FSM state encoding.
package riscpipe_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h6800_0000;
    localparam logic [4:0]  OPCODE_MAX = 5'b10100;
    localparam int          OPC_MSB    = 31;
    localparam int          OPC_LSB    = 27;
    localparam int          IMM_BIT    = 26;
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_HOLD = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic op_illegal(input logic [31:0] instr);
        return opcode_of(instr) > OPCODE_MAX;
    endfunction

    // Byte address forced to a word boundary; all 32 bits are consumed.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_of_reg.sv
// IF/OF pipeline register: flush > hold > load; a bubble is stored as NOP/pc 0.
// With FETCH_ILLEGAL_OP_EN defined, out-of-range opcodes are replaced by NOP and flagged.
module if_of_reg
    import riscpipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        of_valid_o,
    output logic [31:0] of_pc_o,
    output logic [31:0] of_instr_o,
    output logic        of_illegal_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        ill_q, ill_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ill_d   = ill_q;
        if (flush_i || (!hold_i && !load_i)) begin
            valid_d = 1'b0;
            pc_d    = 32'h0;
            instr_d = NOP_INSTR;
            ill_d   = 1'b0;
        end else if (!hold_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
`ifdef FETCH_ILLEGAL_OP_EN
            // Keep the slot valid so the illegal op can trap at its own pc.
            if (op_illegal(instr_i)) begin
                instr_d = NOP_INSTR;
                ill_d   = 1'b1;
            end else begin
                instr_d = instr_i;
                ill_d   = 1'b0;
            end
`else
            instr_d = instr_i;
            ill_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ill_q   <= ill_d;
        end
    end

    assign of_valid_o   = valid_q;
    assign of_pc_o      = pc_q;
    assign of_instr_o   = instr_q;
    assign of_illegal_o = ill_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: request FSM (REQ/HOLD/DROP), one-entry stall buffer, IF/OF register.
// Optional illegal-opcode squashing via FETCH_ILLEGAL_OP_EN (handled in if_of_reg).
module fetch_stage
    import riscpipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    input  logic        stall,
    output logic        of_valid,
    output logic [31:0] of_pc,
    output logic [31:0] of_instr,
    output logic [4:0]  of_opcode,
    output logic        of_imm,
    output logic        of_illegal
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  redir_q;
    logic [31:0]  hb_pc_q;
    logic [31:0]  hb_instr_q;
    logic [31:0]  br_tgt;

    logic         ifof_load;
    logic [31:0]  ifof_pc;
    logic [31:0]  ifof_instr;

    assign br_tgt    = word_align(branch_pc);
    // pc_q stays on the old address through DROP so the in-flight request remains stable.
    assign imem_req  = rst_n && (state_q != FS_HOLD);
    assign imem_addr = pc_q;

    always_comb begin
        ifof_load  = 1'b0;
        ifof_pc    = pc_q;
        ifof_instr = imem_rdata;
        case (state_q)
            FS_REQ:  ifof_load = imem_ack;
            FS_HOLD: begin
                ifof_load  = 1'b1;
                ifof_pc    = hb_pc_q;
                ifof_instr = hb_instr_q;
            end
            default: ifof_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FS_REQ;
            pc_q       <= RESET_PC;
            redir_q    <= 32'h0;
            hb_pc_q    <= 32'h0;
            hb_instr_q <= 32'h0;
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (branch_taken) begin
                        if (imem_ack) begin
                            pc_q <= br_tgt;
                        end else begin
                            redir_q <= br_tgt;
                            state_q <= FS_DROP;
                        end
                    end else if (imem_ack) begin
                        pc_q <= pc_q + PC_STEP;
                        if (stall) begin
                            hb_pc_q    <= pc_q;
                            hb_instr_q <= imem_rdata;
                            state_q    <= FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (branch_taken) begin
                        pc_q    <= br_tgt;
                        state_q <= FS_REQ;
                    end else if (!stall) begin
                        state_q <= FS_REQ;
                    end
                end
                FS_DROP: begin
                    if (imem_ack) begin
                        pc_q    <= branch_taken ? br_tgt : redir_q;
                        state_q <= FS_REQ;
                    end else if (branch_taken) begin
                        redir_q <= br_tgt;
                    end
                end
                default: state_q <= FS_REQ;
            endcase
        end
    end

    if_of_reg u_if_of_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (branch_taken),
        .hold_i       (stall),
        .load_i       (ifof_load),
        .pc_i         (ifof_pc),
        .instr_i      (ifof_instr),
        .of_valid_o   (of_valid),
        .of_pc_o      (of_pc),
        .of_instr_o   (of_instr),
        .of_illegal_o (of_illegal)
    );

    assign of_opcode = of_instr[OPC_MSB:OPC_LSB];
    assign of_imm    = of_instr[IMM_BIT];

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic        stall = 1'b0;
    logic        of_valid;
    logic [31:0] of_pc;
    logic [31:0] of_instr;
    logic [4:0]  of_opcode;
    logic        of_imm;
    logic        of_illegal;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .stall        (stall),
        .of_valid     (of_valid),
        .of_pc        (of_pc),
        .of_instr     (of_instr),
        .of_opcode    (of_opcode),
        .of_imm       (of_imm),
        .of_illegal   (of_illegal)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Model: next fetch address, pending-discard flag with its redirect target,
    // a queue of fetched-but-stalled words, and the IF/OF slot contents.
    logic [31:0] m_pc, m_tgt;
    bit          m_discard;
    logic [63:0] m_buf[$];
    bit          m_ov, m_oill;
    logic [31:0] m_opc, m_oins;

    function automatic bit m_req();
        return rst_n && (m_buf.size() == 0);
    endfunction

    task automatic m_bubble();
        m_ov = 0; m_opc = 32'h0; m_oins = 32'h6800_0000; m_oill = 0;
    endtask

    task automatic m_load(input logic [31:0] pc, input logic [31:0] ins);
        m_ov = 1; m_opc = pc; m_oins = ins; m_oill = 0;
`ifdef FETCH_ILLEGAL_OP_EN
        if (ins[31:27] > 5'd20) begin
            m_oins = 32'h6800_0000;
            m_oill = 1;
        end
`endif
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_discard = 0; m_buf.delete(); m_bubble();
    endtask

    task automatic m_step();
        bit req;
        logic [63:0] e;
        req = m_req();
        if (!rst_n) begin
            m_reset();
        end else if (branch_taken) begin
            m_buf.delete();
            m_bubble();
            if (req && !imem_ack) begin
                m_discard = 1;
                m_tgt = {branch_pc[31:2], 2'b00};
            end else begin
                m_discard = 0;
                m_pc = {branch_pc[31:2], 2'b00};
            end
        end else if (m_buf.size() != 0) begin
            if (!stall) begin
                e = m_buf.pop_front();
                m_load(e[63:32], e[31:0]);
            end
        end else if (m_discard) begin
            if (imem_ack) begin
                m_discard = 0;
                m_pc = m_tgt;
            end
            if (!stall) m_bubble();
        end else if (imem_ack) begin
            if (stall) m_buf.push_back({m_pc, imem_rdata});
            else m_load(m_pc, imem_rdata);
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_bubble();
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
        if (m_req()) chk("imem_addr", imem_addr, m_pc);
        chk("of_valid", {31'h0, of_valid}, {31'h0, m_ov});
        chk("of_pc", of_pc, m_opc);
        chk("of_instr", of_instr, m_oins);
        chk("of_opcode", {27'h0, of_opcode}, {27'h0, m_oins[31:27]});
        chk("of_imm", {31'h0, of_imm}, {31'h0, m_oins[26]});
        chk("of_illegal", {31'h0, of_illegal}, {31'h0, m_oill});
    endtask

    // Called at a negedge: drive, check current outputs, clock, advance model.
    task automatic cyc(input bit r, input bit a, input logic [31:0] d,
                       input bit b, input logic [31:0] bp, input bit s);
        rst_n = r; imem_ack = a; imem_rdata = d;
        branch_taken = b; branch_pc = bp; stall = s;
        #1;
        check_all();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] legal_word(input logic [31:0] pc);
        return {5'b00001, pc[26:0]};
    endfunction

    task automatic do_reset();
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Zero-wait streaming after reset.
        do_reset();
        chk("rst_valid", {31'h0, of_valid}, 32'h0);
        chk("rst_instr", of_instr, 32'h6800_0000);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, legal_word(m_pc), 0, 0, 0);
            chk("seq_pc", of_pc, 32'(i * 4));
            chk("seq_valid", {31'h0, of_valid}, 32'h1);
        end

        // Stall with ack at 0x10 -> HOLD, then release.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, legal_word(m_pc), 0, 0, 0);
        cyc(1, 1, legal_word(32'h10), 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_req", {31'h0, imem_req}, 32'h0);
            chk("hold_ofpc", of_pc, 32'h0C);
            cyc(1, 0, 32'h0, 0, 0, 1);
        end
        cyc(1, 0, 32'h0, 0, 0, 0);
        chk("hold_release", of_pc, 32'h10);
        cyc(1, 1, legal_word(m_pc), 0, 0, 0);
        chk("hold_next", of_pc, 32'h14);

        // Branch with delayed ack -> DROP.
        cyc(1, 0, 32'h0, 1, 32'h103, 0);
        cyc(1, 0, 32'h0, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 0, 0);
        cyc(1, 1, 32'h0BAD_0BAD, 0, 0, 0);
        chk("drop_valid", {31'h0, of_valid}, 32'h0);
        #1;
        chk("drop_addr", imem_addr, 32'h100);
        cyc(1, 1, legal_word(32'h100), 0, 0, 0);
        chk("drop_arrive", of_pc, 32'h100);

        // Branch and stall together while in HOLD.
        cyc(1, 1, legal_word(m_pc), 0, 0, 1);
        cyc(1, 0, 32'h0, 1, 32'h2000, 1);
        chk("hbr_valid", {31'h0, of_valid}, 32'h0);
        #1;
        chk("hbr_addr", imem_addr, 32'h2000);
        chk("hbr_req", {31'h0, imem_req}, 32'h1);

        // PC wrap.
        cyc(1, 1, 32'h0, 1, 32'hFFFF_FFFE, 0);
        cyc(1, 1, legal_word(32'hFFFF_FFFC), 0, 0, 0);
        chk("wrap_pc", of_pc, 32'hFFFF_FFFC);
        #1;
        chk("wrap_addr", imem_addr, 32'h0);

        // Illegal opcode.
        cyc(1, 1, 32'hF800_0000, 0, 0, 0);
`ifdef FETCH_ILLEGAL_OP_EN
        chk("ill_instr", of_instr, 32'h6800_0000);
        chk("ill_flag", {31'h0, of_illegal}, 32'h1);
`else
        chk("ill_instr", of_instr, 32'hF800_0000);
        chk("ill_flag", {31'h0, of_illegal}, 32'h0);
`endif
        chk("ill_valid", {31'h0, of_valid}, 32'h1);

        // Reset in the middle of HOLD.
        cyc(1, 1, legal_word(m_pc), 0, 0, 1);
        do_reset();
        chk("mrst_valid", {31'h0, of_valid}, 32'h0);
        #1;
        chk("mrst_addr", imem_addr, 32'h0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bit r, a, b, s;
            r = ($urandom_range(0, 99) >= 2);
            a = ($urandom_range(0, 99) < 60) && (m_req() || !r);
            b = ($urandom_range(0, 99) < 10);
            s = ($urandom_range(0, 99) < 30);
            cyc(r, a, $urandom, b, $urandom, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
